shifter_pipe: RTL and testbench
===============================

// Module: shifter_pipe
// PURPOSE
//  Parametrised, pipelined barrel shifter for the ALU/datapath library.
//  Supports logical/arithmetic shifts and rotates with a binary shift amount.
//  Elastic valid/ready pipeline with a configurable number of register stages.
//  Also reports the last bit shifted or rotated out (carry).
// PARAMETERS
//  DATA_W  64  operand width; power of two, 8..128
//  STAGES  2   register stages, 0..$clog2(DATA_W); 0 = fully combinational
//  SHAMT_W localparam = $clog2(DATA_W)
// PORTS
//  clk_i        in   1        clock
//  rst_n_i      in   1        reset, asynchronous, active-low
//  in_valid_i   in   1        input operation valid
//  in_ready_o   out  1        block can accept an operation this cycle
//  mode_i       in   3        000 SLL, 001 SRL, 010 SRA, 100 ROL, 101 ROR; others reserved
//  shamt_i      in   SHAMT_W  shift amount, binary, 0..DATA_W-1
//  data_i       in   DATA_W   operand
//  out_valid_o  out  1        result valid
//  out_ready_i  in   1        downstream accepts the result
//  data_o       out  DATA_W   result
//  carry_o      out  1        last bit shifted/rotated out
// BEHAVIOUR
//  - Clock and reset: clk_i clocks the block; rst_n_i is asynchronous, active-low.
//  - Reset state: all stage valids = 0, out_valid_o = 0, data_o = 0, carry_o = 0.
//  - Reset mid-operation: all in-flight operations are dropped; no output appears after release.
//  - Transfer rules:
//    - An input transfer occurs when in_valid_i & in_ready_o.
//    - An output transfer occurs when out_valid_o & out_ready_i.
//  - Structure: SHAMT_W log levels; level k shifts by 2^k when shamt_i[k] is set.
//    - Register stage s (0..STAGES-1) sits after level ceil(SHAMT_W*(s+1)/STAGES)-1.
//    - Mode, the remaining shamt bits and the partial carry travel with the data.
//  - Latency: exactly STAGES cycles from input transfer to out_valid_o when not stalled.
//    - Throughput: 1 operation/cycle.
//  - Handshake:
//    - Stage s loads when its successor is empty or advancing (per-stage bubble collapse).
//    - in_ready_o = ~valid[0] | stage-0 advances; it is combinational from out_ready_i.
//    - While out_valid_o & ~out_ready_i, data_o and carry_o stay stable and no stage overwrites a full stage.
//    - in_valid_i is never required to wait for in_ready_o.
//    - Simultaneous input and output transfers on a full pipe are legal and lossless.
//  - STAGES=0 (combinational):
//    - out_valid_o = in_valid_i, in_ready_o = out_ready_i.
//    - data_o and carry_o are combinational from the inputs.
//  - Results for n = shamt_i:
//    - SLL: zero-fill from the LSB side.
//    - SRL: zero-fill from the MSB side.
//    - SRA: fill with data_i[DATA_W-1].
//    - ROL/ROR: bits wrap around; no fill.
//  - Carry (n>0):
//    - SLL: data_i[DATA_W-n]
//    - SRL/SRA: data_i[n-1]
//    - ROL: result[0]
//    - ROR: result[DATA_W-1]
//  - n=0: data_o = data_i and carry_o = 0 for all modes.
//  - Reserved modes: data_o = data_i, carry_o = 0; these operations still consume a slot and latency.
//  - data_o and carry_o hold their last value when out_valid_o = 0.
// TESTING (DATA_W=64, STAGES=2 unless noted)
//  - SRA:
//    - data 0x8000_0000_0000_00F0, n=4 -> 0xF800_0000_0000_000F, carry 0.
//    - Same data, n=63 -> all-ones, carry 0.
//  - SLL/ROR:
//    - SLL data 0xC000_0000_0000_0001, n=1 -> 0x8000_0000_0000_0002, carry 1.
//    - ROR data 0x1, n=1 -> 0x8000_0000_0000_0000, carry 1.
//  - Back-to-back: 8 operations on consecutive cycles with out_ready_i=1
//    -> out_valid_o asserted on cycles 2..9; results in order.
//  - Backpressure: hold out_ready_i=0 for 5 cycles during a stream
//    -> in_ready_o drops after 2 accepts; data_o stable; no loss or duplication.
//  - Reset: assert rst_n_i with 2 operations in flight
//    -> out_valid_o=0, data_o=0 immediately; nothing emitted after release.
//  - Sweep: STAGES=0,1,6 with random mode/shamt/data vs a reference model
//    -> exact match; STAGES=0 gives same-cycle results.

Source files
------------

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with elastic valid/ready stages.
// Also reports the last bit shifted or rotated out on carry_o.
module shifter_pipe #(
   parameter int  DATA_W  = 64,
   parameter int  STAGES  = 2,
   localparam int SHAMT_W = $clog2(DATA_W)
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [2:0]         mode_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   input  logic [DATA_W-1:0]  data_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [DATA_W-1:0]  data_o,
   output logic               carry_o
);

   localparam logic [2:0] M_SLL = 3'b000;
   localparam logic [2:0] M_SRL = 3'b001;
   localparam logic [2:0] M_SRA = 3'b010;
   localparam logic [2:0] M_ROL = 3'b100;
   localparam logic [2:0] M_ROR = 3'b101;
   localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

   typedef struct packed {
      logic [2:0]         mode;
      logic [SHAMT_W-1:0] sh;
      logic               carry;
      logic [DATA_W-1:0]  data;
   } pl_t;

   // Last log level (inclusive) handled before register stage s; s = -1 gives -1.
   function automatic int lvl_hi(input int s);
      if (STAGES == 0) return SHAMT_W - 1;
      return (SHAMT_W * (s + 1) + STAGES - 1) / STAGES - 1;
   endfunction

   // One log level: shift by 2^k when shamt bit k is set. The carry left behind by
   // the highest applied level is the overall last bit out, so it is simply overwritten.
   function automatic pl_t level_op(input pl_t p, input int k);
      pl_t                r;
      logic [SHAMT_W-1:0] sh_k;
      int                 amt;
      r    = p;
      amt  = 1 << k;
      sh_k = p.sh >> k;
      if (sh_k[0]) begin
         case (p.mode)
            M_SLL: begin
               r.data  = p.data << amt;
               r.carry = |(p.data & (ONE << (DATA_W - amt)));
            end
            M_SRL: begin
               r.data  = p.data >> amt;
               r.carry = |(p.data & (ONE << (amt - 1)));
            end
            M_SRA: begin
               r.data  = $signed(p.data) >>> amt;
               r.carry = |(p.data & (ONE << (amt - 1)));
            end
            M_ROL: begin
               r.data  = (p.data << amt) | (p.data >> (DATA_W - amt));
               r.carry = |(p.data & (ONE << (DATA_W - amt)));
            end
            M_ROR: begin
               r.data  = (p.data >> amt) | (p.data << (DATA_W - amt));
               r.carry = |(p.data & (ONE << (amt - 1)));
            end
            default: r = p;
         endcase
      end
      return r;
   endfunction

   pl_t in_pl;
   assign in_pl = {mode_i, shamt_i, 1'b0, data_i};

   if (STAGES == 0) begin : g_comb
      pl_t res;
      always_comb begin
         res = in_pl;
         for (int k = 0; k < SHAMT_W; k++) res = level_op(res, k);
      end
      assign out_valid_o = in_valid_i;
      assign in_ready_o  = out_ready_i;
      assign data_o      = res.data;
      assign carry_o     = res.carry;
   end else begin : g_pipe
      pl_t               src  [STAGES];
      pl_t               pl_d [STAGES];
      pl_t               pl_q [STAGES];
      logic [STAGES-1:0] vld_q;
      logic [STAGES-1:0] up_vld;
      logic [STAGES:0]   rdy;

      always_comb begin
         src[0]    = in_pl;
         up_vld[0] = in_valid_i;
         for (int s = 1; s < STAGES; s++) begin
            src[s]    = pl_q[s-1];
            up_vld[s] = vld_q[s-1];
         end
         for (int s = 0; s < STAGES; s++) begin
            pl_d[s] = src[s];
            for (int k = 0; k < SHAMT_W; k++) begin
               if (k > lvl_hi(s - 1) && k <= lvl_hi(s)) pl_d[s] = level_op(pl_d[s], k);
            end
         end
         // A stage may load when it is empty or its content moves on this cycle.
         rdy[STAGES] = out_ready_i;
         for (int s = STAGES - 1; s >= 0; s--) rdy[s] = ~vld_q[s] | rdy[s+1];
      end

      always_ff @(posedge clk_i or negedge rst_n_i) begin
         if (!rst_n_i) begin
            vld_q <= '0;
            for (int s = 0; s < STAGES; s++) pl_q[s] <= '0;
         end else begin
            for (int s = 0; s < STAGES; s++) begin
               if (rdy[s]) begin
                  vld_q[s] <= up_vld[s];
                  if (up_vld[s]) pl_q[s] <= pl_d[s];
               end
            end
         end
      end

      assign in_ready_o  = rdy[0];
      assign out_valid_o = vld_q[STAGES-1];
      assign data_o      = pl_q[STAGES-1].data;
      assign carry_o     = pl_q[STAGES-1].carry;
   end

endmodule

// File: tb/tb_shifter_pipe.sv
// Scoreboard bench for shifter_pipe: directed vectors on a 2-stage pipe plus a
// reference-model sweep on 0-, 1- and 6-stage instances.
module tb_shifter_pipe;
   localparam int W = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          in_valid, in_ready, out_valid, out_ready, cout;
   logic [2:0]    mode;
   logic [5:0]    shamt;
   logic [W-1:0]  data, dout;

   logic          sw_valid, sw_ready;
   logic [2:0]    sw_mode;
   logic [5:0]    sw_sh;
   logic [W-1:0]  sw_data;
   logic          s0_ir, s0_ov, s0_c, s1_ir, s1_ov, s1_c, s6_ir, s6_ov, s6_c;
   logic [W-1:0]  s0_d, s1_d, s6_d;

   shifter_pipe #(.DATA_W(W), .STAGES(2)) u_dut (
      .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .mode_i(mode), .shamt_i(shamt), .data_i(data), .out_valid_o(out_valid),
      .out_ready_i(out_ready), .data_o(dout), .carry_o(cout));

   shifter_pipe #(.DATA_W(W), .STAGES(0)) u_s0 (
      .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(sw_valid), .in_ready_o(s0_ir),
      .mode_i(sw_mode), .shamt_i(sw_sh), .data_i(sw_data), .out_valid_o(s0_ov),
      .out_ready_i(sw_ready), .data_o(s0_d), .carry_o(s0_c));

   shifter_pipe #(.DATA_W(W), .STAGES(1)) u_s1 (
      .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(sw_valid), .in_ready_o(s1_ir),
      .mode_i(sw_mode), .shamt_i(sw_sh), .data_i(sw_data), .out_valid_o(s1_ov),
      .out_ready_i(sw_ready), .data_o(s1_d), .carry_o(s1_c));

   shifter_pipe #(.DATA_W(W), .STAGES(6)) u_s6 (
      .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(sw_valid), .in_ready_o(s6_ir),
      .mode_i(sw_mode), .shamt_i(sw_sh), .data_i(sw_data), .out_valid_o(s6_ov),
      .out_ready_i(sw_ready), .data_o(s6_d), .carry_o(s6_c));

   typedef struct {
      logic [2:0]   m;
      logic [5:0]   n;
      logic [W-1:0] d;
      logic [W-1:0] r;
      logic         c;
   } vec_t;

   typedef struct {
      logic [W-1:0] d;
      logic         c;
      int           cyc;
   } exp_t;

   vec_t vecs [15];
   exp_t q_main[$], q1[$], q6[$];
   bit   lat_chk = 1'b0;
   int   n_acc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
   endtask

   function automatic logic [64:0] ref_op(input logic [2:0] m, input logic [5:0] n,
                                          input logic [W-1:0] d);
      logic [2*W-1:0] dd;
      logic [W-1:0]   r, t;
      logic           c;
      int             k;
      k = int'(n);
      r = d;
      c = 1'b0;
      dd = '0;
      t = '0;
      if (k != 0) begin
         case (m)
            3'b000: begin r = d << k; t = d >> (W - k); c = t[0]; end
            3'b001: begin r = d >> k; t = d >> (k - 1); c = t[0]; end
            3'b010: begin r = $signed(d) >>> k; t = d >> (k - 1); c = t[0]; end
            3'b100: begin dd = {d, d} << k; r = dd[2*W-1:W]; c = r[0]; end
            3'b101: begin dd = {d, d} >> k; r = dd[W-1:0]; c = r[W-1]; end
            default: ;
         endcase
      end
      return {c, r};
   endfunction

   // Drive at posedge+1, decide acceptance at the following negedge.
   task automatic send(input vec_t v);
      int t;
      t = 0;
      mode = v.m; shamt = v.n; data = v.d; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         t++;
         @(negedge clk);
      end
      if (!in_ready) timeout("send_accept");
      else begin
         q_main.push_back('{v.r, v.c, cyc});
         n_acc++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((q_main.size() != 0 || q1.size() != 0 || q6.size() != 0) && t < 200) begin
         t++;
         @(negedge clk);
      end
      if (q_main.size() != 0 || q1.size() != 0 || q6.size() != 0) timeout("drain");
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin : mon_main
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         if (q_main.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL main_unexpected: got %h expected no output", {cout, dout});
         end else begin
            e = q_main.pop_front();
            check("main_result", {cout, dout}, {e.c, e.d});
            if (lat_chk) check("main_latency", 65'(cyc - e.cyc), 65'(2));
         end
      end
   end

   always @(negedge clk) begin : mon_s1
      exp_t e;
      if (rst_n && s1_ov) begin
         if (q1.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL s1_unexpected: got %h expected no output", {s1_c, s1_d});
         end else begin
            e = q1.pop_front();
            check("s1_result", {s1_c, s1_d}, {e.c, e.d});
            check("s1_latency", 65'(cyc - e.cyc), 65'(1));
         end
      end
   end

   always @(negedge clk) begin : mon_s6
      exp_t e;
      if (rst_n && s6_ov) begin
         if (q6.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL s6_unexpected: got %h expected no output", {s6_c, s6_d});
         end else begin
            e = q6.pop_front();
            check("s6_result", {s6_c, s6_d}, {e.c, e.d});
            check("s6_latency", 65'(cyc - e.cyc), 65'(6));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [64:0] r;
      int          n_post;
      bit          done;

      vecs[0]  = '{3'b010, 6'd4,  64'h8000_0000_0000_00F0, 64'hF800_0000_0000_000F, 1'b0};
      vecs[1]  = '{3'b010, 6'd63, 64'h8000_0000_0000_00F0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
      vecs[2]  = '{3'b000, 6'd1,  64'hC000_0000_0000_0001, 64'h8000_0000_0000_0002, 1'b1};
      vecs[3]  = '{3'b101, 6'd1,  64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000, 1'b1};
      vecs[4]  = '{3'b001, 6'd5,  64'h0000_0000_0000_00F0, 64'h0000_0000_0000_0007, 1'b1};
      vecs[5]  = '{3'b100, 6'd1,  64'h8000_0000_0000_0001, 64'h0000_0000_0000_0003, 1'b1};
      vecs[6]  = '{3'b000, 6'd0,  64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0};
      vecs[7]  = '{3'b011, 6'd5,  64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 1'b0};
      vecs[8]  = '{3'b111, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
      vecs[9]  = '{3'b000, 6'd63, 64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000, 1'b0};
      vecs[10] = '{3'b001, 6'd63, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b0};
      vecs[11] = '{3'b101, 6'd4,  64'h1234_5678_9ABC_DEF0, 64'h0123_4567_89AB_CDEF, 1'b0};
      vecs[12] = '{3'b100, 6'd4,  64'h1234_5678_9ABC_DEF0, 64'h2345_6789_ABCD_EF01, 1'b1};
      vecs[13] = '{3'b010, 6'd62, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b1};
      vecs[14] = '{3'b000, 6'd32, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_0000_0000, 1'b1};

      in_valid = 1'b0; out_ready = 1'b1; mode = '0; shamt = '0; data = '0;
      sw_valid = 1'b0; sw_ready = 1'b1; sw_mode = '0; sw_sh = '0; sw_data = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_out_valid", 65'(out_valid), 65'(0));
      check("rst_data_carry", {cout, dout}, 65'(0));
      check("rst_in_ready", 65'(in_ready), 65'(1));
      check("rst_s6_out_valid", 65'(s6_ov), 65'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Back-to-back directed vectors, fixed two-cycle latency
      lat_chk = 1'b1;
      for (int i = 0; i < 15; i++) send(vecs[i]);
      drain();
      lat_chk = 1'b0;

      // Backpressure: out_ready low for five cycles while streaming
      out_ready = 1'b0;
      n_acc = 0;
      fork
         begin
            for (int i = 0; i < 8; i++) send(vecs[i]);
         end
         begin
            repeat (3) @(negedge clk);
            for (int j = 0; j < 3; j++) begin
               if (j > 0) @(negedge clk);
               check("bp_in_ready", 65'(in_ready), 65'(0));
               check("bp_out_valid", 65'(out_valid), 65'(1));
               check("bp_hold_data", {cout, dout}, {vecs[0].c, vecs[0].r});
            end
            check("bp_accepts", 65'(n_acc), 65'(2));
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Random output backpressure
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 15; i++) send(vecs[i]);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset with two operations in flight
      send(vecs[2]);
      send(vecs[3]);
      rst_n = 1'b0;
      #1;
      check("rstmid_out_valid", 65'(out_valid), 65'(0));
      check("rstmid_data_carry", {cout, dout}, 65'(0));
      q_main.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      n_post = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) n_post++;
      end
      check("rstmid_no_output", 65'(n_post), 65'(0));
      @(posedge clk); #1;

      // Reference-model sweep on 0/1/6-stage instances
      for (int i = 0; i < 80; i++) begin
         sw_valid = ($urandom_range(0, 3) != 0);
         sw_mode  = 3'($urandom_range(0, 7));
         sw_sh    = 6'($urandom_range(0, 63));
         sw_data  = {$urandom, $urandom};
         @(negedge clk);
         r = ref_op(sw_mode, sw_sh, sw_data);
         if (sw_valid) begin
            check("s0_result", {s0_c, s0_d}, r);
            check("s0_out_valid", 65'(s0_ov), 65'(1));
            check("s6_in_ready", 65'(s6_ir), 65'(1));
            if (s1_ir) q1.push_back('{r[63:0], r[64], cyc});
            if (s6_ir) q6.push_back('{r[63:0], r[64], cyc});
         end
         @(posedge clk); #1;
      end
      sw_valid = 1'b0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
